qcore_ctrl_pipe: RTL and testbench
==================================

QCORE_CTRL_PIPE -- requirements
Module: qcore_ctrl_pipe

Interface
REQ-001 SHALL have parameter STALL_MAX, default 16, consecutive stall cycles (1..255) that set stall_err_o.
REQ-002 SHALL have port clk_i  in  1  clock; all state on rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port halt_i  in  1  freeze entire pipeline.
REQ-005 SHALL have port id_vld_i  in  1  ID stage holds valid instruction.
REQ-006 SHALL have port id_desc_i  in  12  ID descriptor {port_re[11], r_wave_we[10], src[9:8], addr[7:1], we[0]}.
REQ-007 SHALL have port bubble_id_i  in  1  hazard unit: hold ID, inject bubble into RD.
REQ-008 SHALL have port bubble_rd_i  in  1  hazard unit: hold ID and RD, inject bubble into X1.
REQ-009 SHALL have port flush_i  in  1  taken jump: kill ID instruction.
REQ-010 SHALL have port clr_i  in  1  clear stall counters and error.
REQ-011 SHALL have port pc_en_o  out  1  fetch/PC advance enable.
REQ-012 SHALL have port id_en_o  out  1  ID register load enable.
REQ-013 SHALL have ports rd_desc_o, x1_desc_o, x2_desc_o, wr_desc_o  out  12 each  stage descriptors, same packing as id_desc_i.
REQ-014 SHALL have ports rd_vld_o, x1_vld_o, x2_vld_o, wr_vld_o  out  1 each  stage valid.
REQ-015 SHALL have port flush_pend_o  out  1  deferred flush pending.
REQ-016 SHALL have port stall_cnt_o  out  32  total stall cycles, saturating.
REQ-017 SHALL have port stall_err_o  out  1  sticky stall-timeout flag.

Function
REQ-018 SHALL define a bubble as descriptor 12'h000 with valid 0.
REQ-019 SHALL apply priority halt_i > bubble_rd_i > flush (flush_i or flush_pend_o) > bubble_id_i > normal advance.
REQ-020 Halt: all stage registers, counters, flush_pend hold; pc_en_o=id_en_o=0.
REQ-021 Normal advance: RD<=ID (desc, id_vld_i), X1<=RD, X2<=X1, WR<=X2; pc_en_o=id_en_o=1.
REQ-022 bubble_rd_i: RD holds; X1<=bubble; X2<=X1; WR<=X2; pc_en_o=id_en_o=0.
REQ-023 bubble_id_i (no higher-priority event): RD<=bubble; X1<=RD; X2<=X1; WR<=X2; pc_en_o=id_en_o=0.
REQ-024 Flush: RD<=bubble; X1<=RD; X2<=X1; WR<=X2; pc_en_o=id_en_o=1; clears flush_pend_o; concurrent bubble_id_i ignored.
REQ-025 flush_i coincident with bubble_rd_i (not halt) SHALL set flush_pend_o next cycle; the flush is then applied on the first cycle without halt_i and bubble_rd_i.
REQ-026 flush_i coincident with halt_i SHALL be lost (upstream re-asserts).
REQ-027 pc_en_o and id_en_o SHALL be combinational from current inputs and flush_pend_o; all other outputs registered.
REQ-028 Stall cycle = bubble_rd_i or bubble_id_i taking effect per REQ-019 (not halted, not flushing).
REQ-029 stall_cnt_o SHALL increment by 1 per stall cycle and saturate at 32'hFFFFFFFF.
REQ-030 Internal 8-bit consecutive counter SHALL increment per stall cycle, hold on halt, reset to 0 on any advance or flush cycle.
REQ-031 Consecutive counter reaching STALL_MAX SHALL set stall_err_o the next cycle; it stays set until clr_i or reset; the counter saturates at STALL_MAX.
REQ-032 clr_i SHALL zero stall_cnt_o, the consecutive counter and stall_err_o next cycle, overriding same-cycle increment; it does not affect the pipeline.
REQ-033 Descriptor fields SHALL pass unmodified; the block never decodes src/addr.

Reset
REQ-034 On rst_ni low, all descriptors 0, all valids 0, flush_pend_o 0, stall_cnt_o 0, consecutive counter 0, stall_err_o 0, regardless of clock.
REQ-035 While rst_ni is low, pc_en_o and id_en_o SHALL be 0; reset mid-stall discards all in-flight stages.

Verification
REQ-036 Stream 4 valid descriptors 12'h001,002,003,004 with no hazards -> each appears at wr_desc_o exactly 4 cycles after entering ID, valid 1.
REQ-037 RD=12'h083, assert bubble_id_i 1 cycle -> next cycle rd_desc_o=0, rd_vld_o=0, x1_desc_o=12'h083, pc_en_o=0 during the bubble; stall_cnt_o=1.
REQ-038 bubble_rd_i for 3 cycles with RD=12'h0A5 -> rd_desc_o stays 12'h0A5, x1 carries 3 bubbles, stall_cnt_o=3, then normal advance resumes.
REQ-039 flush_i with bubble_rd_i in the same cycle -> flush_pend_o=1 next cycle; bubble_rd_i drops -> RD gets bubble, flush_pend_o=0, pc_en_o=1 that cycle.
REQ-040 STALL_MAX=4, bubble_id_i held 4 cycles with halt_i inserted for 2 cycles mid-sequence -> stall_err_o=1 after 4th stall cycle, stall_cnt_o=4; clr_i -> both 0.
REQ-041 rst_ni low mid-stream with all stages valid -> all valids and counters 0 asynchronously; stall_cnt_o at 32'hFFFFFFFF with further stalls stays saturated.

Source files
------------

// File: rtl/qcore_ctrl_pipe.sv
// Control pipeline for the qcore datapath: moves instruction descriptors ID->RD->X1->X2->WR
// under halt/bubble/flush control and keeps stall statistics with a sticky timeout flag.
module qcore_ctrl_pipe #(
  parameter int unsigned STALL_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        halt_i,
  input  logic        id_vld_i,
  input  logic [11:0] id_desc_i,
  input  logic        bubble_id_i,
  input  logic        bubble_rd_i,
  input  logic        flush_i,
  input  logic        clr_i,
  output logic        pc_en_o,
  output logic        id_en_o,
  output logic [11:0] rd_desc_o,
  output logic [11:0] x1_desc_o,
  output logic [11:0] x2_desc_o,
  output logic [11:0] wr_desc_o,
  output logic        rd_vld_o,
  output logic        x1_vld_o,
  output logic        x2_vld_o,
  output logic        wr_vld_o,
  output logic        flush_pend_o,
  output logic [31:0] stall_cnt_o,
  output logic        stall_err_o
);

  localparam logic [7:0]  STALL_MAX_C = 8'(STALL_MAX);
  localparam logic [31:0] CNT_SAT_C   = 32'hFFFF_FFFF;

  logic [11:0] rd_desc_r, x1_desc_r, x2_desc_r, wr_desc_r;
  logic        rd_vld_r, x1_vld_r, x2_vld_r, wr_vld_r;
  logic        flush_pend_r;
  logic [31:0] stall_cnt_r;
  logic [7:0]  consec_r;
  logic        stall_err_r;

  logic [11:0] rd_desc_s, x1_desc_s, x2_desc_s, wr_desc_s;
  logic        rd_vld_s, x1_vld_s, x2_vld_s, wr_vld_s;
  logic        flush_pend_s;
  logic [31:0] stall_cnt_s;
  logic [7:0]  consec_s;
  logic        stall_err_s;
  logic        fetch_en_s;
  logic        flush_s;
  logic        stall_s;

  assign flush_s = flush_i | flush_pend_r;
  assign stall_s = ~halt_i & (bubble_rd_i | (bubble_id_i & ~flush_s));

  // Stage advance selection: halt > bubble_rd > flush > bubble_id > normal advance
  always_comb begin
    rd_desc_s    = rd_desc_r;
    rd_vld_s     = rd_vld_r;
    x1_desc_s    = x1_desc_r;
    x1_vld_s     = x1_vld_r;
    x2_desc_s    = x2_desc_r;
    x2_vld_s     = x2_vld_r;
    wr_desc_s    = wr_desc_r;
    wr_vld_s     = wr_vld_r;
    flush_pend_s = flush_pend_r;
    fetch_en_s   = 1'b0;
    if (halt_i) begin
      fetch_en_s = 1'b0;
    end else if (bubble_rd_i) begin
      x1_desc_s    = 12'h000;
      x1_vld_s     = 1'b0;
      x2_desc_s    = x1_desc_r;
      x2_vld_s     = x1_vld_r;
      wr_desc_s    = x2_desc_r;
      wr_vld_s     = x2_vld_r;
      flush_pend_s = flush_pend_r | flush_i;
    end else begin
      x1_desc_s    = rd_desc_r;
      x1_vld_s     = rd_vld_r;
      x2_desc_s    = x1_desc_r;
      x2_vld_s     = x1_vld_r;
      wr_desc_s    = x2_desc_r;
      wr_vld_s     = x2_vld_r;
      flush_pend_s = 1'b0;
      if (flush_s) begin
        rd_desc_s  = 12'h000;
        rd_vld_s   = 1'b0;
        fetch_en_s = 1'b1;
      end else if (bubble_id_i) begin
        rd_desc_s  = 12'h000;
        rd_vld_s   = 1'b0;
        fetch_en_s = 1'b0;
      end else begin
        rd_desc_s  = id_desc_i;
        rd_vld_s   = id_vld_i;
        fetch_en_s = 1'b1;
      end
    end
  end

  // Stall statistics: clr wins, halt freezes, any non-stall cycle restarts the run length
  always_comb begin
    stall_cnt_s = stall_cnt_r;
    consec_s    = consec_r;
    stall_err_s = stall_err_r;
    if (clr_i) begin
      stall_cnt_s = 32'h0000_0000;
      consec_s    = 8'h00;
      stall_err_s = 1'b0;
    end else if (halt_i) begin
      stall_cnt_s = stall_cnt_r;
    end else if (stall_s) begin
      stall_cnt_s = (stall_cnt_r == CNT_SAT_C) ? stall_cnt_r : stall_cnt_r + 32'd1;
      if (consec_r >= STALL_MAX_C - 8'd1) begin
        consec_s    = STALL_MAX_C;
        stall_err_s = 1'b1;
      end else begin
        consec_s    = consec_r + 8'd1;
      end
    end else begin
      consec_s = 8'h00;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_desc_r    <= 12'h000;
      x1_desc_r    <= 12'h000;
      x2_desc_r    <= 12'h000;
      wr_desc_r    <= 12'h000;
      rd_vld_r     <= 1'b0;
      x1_vld_r     <= 1'b0;
      x2_vld_r     <= 1'b0;
      wr_vld_r     <= 1'b0;
      flush_pend_r <= 1'b0;
      stall_cnt_r  <= 32'h0000_0000;
      consec_r     <= 8'h00;
      stall_err_r  <= 1'b0;
    end else begin
      rd_desc_r    <= rd_desc_s;
      x1_desc_r    <= x1_desc_s;
      x2_desc_r    <= x2_desc_s;
      wr_desc_r    <= wr_desc_s;
      rd_vld_r     <= rd_vld_s;
      x1_vld_r     <= x1_vld_s;
      x2_vld_r     <= x2_vld_s;
      wr_vld_r     <= wr_vld_s;
      flush_pend_r <= flush_pend_s;
      stall_cnt_r  <= stall_cnt_s;
      consec_r     <= consec_s;
      stall_err_r  <= stall_err_s;
    end
  end

  assign pc_en_o      = fetch_en_s & rst_ni;
  assign id_en_o      = fetch_en_s & rst_ni;
  assign rd_desc_o    = rd_desc_r;
  assign x1_desc_o    = x1_desc_r;
  assign x2_desc_o    = x2_desc_r;
  assign wr_desc_o    = wr_desc_r;
  assign rd_vld_o     = rd_vld_r;
  assign x1_vld_o     = x1_vld_r;
  assign x2_vld_o     = x2_vld_r;
  assign wr_vld_o     = wr_vld_r;
  assign flush_pend_o = flush_pend_r;
  assign stall_cnt_o  = stall_cnt_r;
  assign stall_err_o  = stall_err_r;

endmodule

// File: tb/tb_qcore_ctrl_pipe.sv
// Directed self-checking bench for qcore_ctrl_pipe (STALL_MAX=4): streaming, bubbles,
// deferred flush, halt interaction, stall timeout, async reset and counter saturation.
module tb_qcore_ctrl_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        halt_i, id_vld_i, bubble_id_i, bubble_rd_i, flush_i, clr_i;
  logic [11:0] id_desc_i;
  logic        pc_en_o, id_en_o;
  logic [11:0] rd_desc_o, x1_desc_o, x2_desc_o, wr_desc_o;
  logic        rd_vld_o, x1_vld_o, x2_vld_o, wr_vld_o;
  logic        flush_pend_o, stall_err_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  qcore_ctrl_pipe #(.STALL_MAX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .halt_i(halt_i), .id_vld_i(id_vld_i),
    .id_desc_i(id_desc_i), .bubble_id_i(bubble_id_i), .bubble_rd_i(bubble_rd_i),
    .flush_i(flush_i), .clr_i(clr_i), .pc_en_o(pc_en_o), .id_en_o(id_en_o),
    .rd_desc_o(rd_desc_o), .x1_desc_o(x1_desc_o), .x2_desc_o(x2_desc_o),
    .wr_desc_o(wr_desc_o), .rd_vld_o(rd_vld_o), .x1_vld_o(x1_vld_o),
    .x2_vld_o(x2_vld_o), .wr_vld_o(wr_vld_o), .flush_pend_o(flush_pend_o),
    .stall_cnt_o(stall_cnt_o), .stall_err_o(stall_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; halt_i = 1'b0; id_vld_i = 1'b0; id_desc_i = 12'h000;
    bubble_id_i = 1'b0; bubble_rd_i = 1'b0; flush_i = 1'b0; clr_i = 1'b0;
    #1;
    check_eq("rst_rd_vld", 32'(rd_vld_o), 32'd0);
    check_eq("rst_wr_vld", 32'(wr_vld_o), 32'd0);
    check_eq("rst_cnt", stall_cnt_o, 32'd0);
    check_eq("rst_err", 32'(stall_err_o), 32'd0);
    check_eq("rst_pc_en", 32'(pc_en_o), 32'd0);
    check_eq("rst_id_en", 32'(id_en_o), 32'd0);
    #7 rst_ni = 1'b1;

    // four-deep stream: descriptor entering ID before edge s reaches WR after edge s+3
    for (int s = 1; s <= 8; s++) begin
      if (s <= 4) begin
        id_vld_i = 1'b1; id_desc_i = 12'(s);
      end else begin
        id_vld_i = 1'b0; id_desc_i = 12'h000;
      end
      #1 check_eq("adv_pc_en", 32'(pc_en_o), 32'd1);
      step();
      if (s >= 4 && s <= 7) begin
        check_eq("stream_wr_desc", 32'(wr_desc_o), 32'(s - 3));
        check_eq("stream_wr_vld", 32'(wr_vld_o), 32'd1);
      end else begin
        check_eq("stream_wr_desc", 32'(wr_desc_o), 32'd0);
        check_eq("stream_wr_vld", 32'(wr_vld_o), 32'd0);
      end
    end

    // single ID bubble
    id_vld_i = 1'b1; id_desc_i = 12'h083; step();
    check_eq("bid_rd_pre", 32'(rd_desc_o), 32'h083);
    bubble_id_i = 1'b1;
    #1 check_eq("bid_pc_en", 32'(pc_en_o), 32'd0);
    check_eq("bid_id_en", 32'(id_en_o), 32'd0);
    step();
    check_eq("bid_rd_desc", 32'(rd_desc_o), 32'd0);
    check_eq("bid_rd_vld", 32'(rd_vld_o), 32'd0);
    check_eq("bid_x1_desc", 32'(x1_desc_o), 32'h083);
    check_eq("bid_x1_vld", 32'(x1_vld_o), 32'd1);
    check_eq("bid_cnt", stall_cnt_o, 32'd1);
    bubble_id_i = 1'b0; id_vld_i = 1'b0; id_desc_i = 12'h000;
    repeat (4) step();

    // three-cycle RD hold
    id_vld_i = 1'b1; id_desc_i = 12'h0A5; step();
    check_eq("brd_rd_pre", 32'(rd_desc_o), 32'h0A5);
    id_desc_i = 12'h0B6; bubble_rd_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("brd_rd_hold", 32'(rd_desc_o), 32'h0A5);
      check_eq("brd_x1_bubble", {19'd0, x1_vld_o, x1_desc_o}, 32'd0);
    end
    check_eq("brd_cnt", stall_cnt_o, 32'd4);
    bubble_rd_i = 1'b0;
    #1 check_eq("brd_resume_pc_en", 32'(pc_en_o), 32'd1);
    step();
    check_eq("brd_resume_rd", 32'(rd_desc_o), 32'h0B6);
    check_eq("brd_resume_x1", 32'(x1_desc_o), 32'h0A5);
    check_eq("brd_no_err", 32'(stall_err_o), 32'd0);

    // flush deferred behind bubble_rd
    id_desc_i = 12'h0C7; bubble_rd_i = 1'b1; flush_i = 1'b1; step();
    check_eq("fp_set", 32'(flush_pend_o), 32'd1);
    check_eq("fp_rd_hold", 32'(rd_desc_o), 32'h0B6);
    check_eq("fp_cnt", stall_cnt_o, 32'd5);
    bubble_rd_i = 1'b0; flush_i = 1'b0;
    #1 check_eq("fp_pc_en", 32'(pc_en_o), 32'd1);
    step();
    check_eq("fp_rd_bubble", {19'd0, rd_vld_o, rd_desc_o}, 32'd0);
    check_eq("fp_clear", 32'(flush_pend_o), 32'd0);
    check_eq("fp_x1", 32'(x1_desc_o), 32'h0B6);
    check_eq("fp_cnt_hold", stall_cnt_o, 32'd5);

    // flush during halt is dropped
    halt_i = 1'b1; flush_i = 1'b1;
    #1 check_eq("halt_pc_en", 32'(pc_en_o), 32'd0);
    step();
    check_eq("halt_flush_lost", 32'(flush_pend_o), 32'd0);
    halt_i = 1'b0; flush_i = 1'b0; id_desc_i = 12'h0D8; step();
    check_eq("halt_after_rd", {19'd0, rd_vld_o, rd_desc_o}, 32'h10D8);

    // stall timeout with halt interleaved
    clr_i = 1'b1; step();
    check_eq("clr_cnt", stall_cnt_o, 32'd0);
    clr_i = 1'b0; bubble_id_i = 1'b1;
    step(); step();
    halt_i = 1'b1; step(); step();
    check_eq("to_halt_cnt", stall_cnt_o, 32'd2);
    check_eq("to_halt_err", 32'(stall_err_o), 32'd0);
    halt_i = 1'b0; step();
    check_eq("to_3_err", 32'(stall_err_o), 32'd0);
    step();
    check_eq("to_4_err", 32'(stall_err_o), 32'd1);
    check_eq("to_4_cnt", stall_cnt_o, 32'd4);
    bubble_id_i = 1'b0; step();
    check_eq("to_sticky", 32'(stall_err_o), 32'd1);
    bubble_id_i = 1'b1; clr_i = 1'b1; step();
    check_eq("to_clr_cnt", stall_cnt_o, 32'd0);
    check_eq("to_clr_err", 32'(stall_err_o), 32'd0);
    bubble_id_i = 1'b0; clr_i = 1'b0;

    // async reset with every stage valid
    bubble_id_i = 1'b1; step(); bubble_id_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id_vld_i = 1'b1; id_desc_i = 12'h0E1 + 12'(i); step();
    end
    check_eq("full_wr", {19'd0, wr_vld_o, wr_desc_o}, 32'h10E1);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_vlds", {28'd0, rd_vld_o, x1_vld_o, x2_vld_o, wr_vld_o}, 32'd0);
    check_eq("arst_wr_desc", 32'(wr_desc_o), 32'd0);
    check_eq("arst_cnt", stall_cnt_o, 32'd0);
    check_eq("arst_pc_en", 32'(pc_en_o), 32'd0);
    id_vld_i = 1'b0; id_desc_i = 12'h000;
    #1 rst_ni = 1'b1;

    // saturation from a preloaded near-full count
    force dut.stall_cnt_r = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_r;
    bubble_id_i = 1'b1; step();
    check_eq("sat_reach", stall_cnt_o, 32'hFFFF_FFFF);
    step();
    check_eq("sat_hold", stall_cnt_o, 32'hFFFF_FFFF);
    bubble_id_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
